// File: rtl/ram_sp_bidir_if.sv
// Control bundle for the bidirectional single-port RAM: word address and
// direction select. The data bus stays a plain inout on the RAM itself.
interface ram_sp_bidir_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;

    modport master (output addr, output wr_en);
    modport slave  (input  addr, input  wr_en);
endinterface

// File: rtl/ram_sp_bidir.sv
// Single-port flop-based RAM on a shared tri-state data bus. wr_en = 1 captures
// the bus into mem[addr]; wr_en = 0 loads rd_q and drives it back onto the bus.
module ram_sp_bidir #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_sp_bidir_if.slave         ctrl,
    inout  wire  [DATA_WIDTH-1:0] data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem   [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] mem_d [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_d;
    logic                  drive_en_s;

    // Next-state for storage and read register from the sampled direction.
    always_comb begin
        mem_d = mem;
        rd_d  = rd_q;
        if (ctrl.wr_en) begin
            mem_d[ctrl.addr] = data;
        end else begin
            rd_d = mem[ctrl.addr];
        end
    end

    // State registers; reset clears every word without needing a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {DATA_WIDTH{1'b0}};
            end
            rd_q <= {DATA_WIDTH{1'b0}};
        end else begin
            mem  <= mem_d;
            rd_q <= rd_d;
        end
    end

    // Output enable is combinational so the bus is released the instant wr_en rises.
    assign drive_en_s = rst_n & ~ctrl.wr_en;
    assign data       = drive_en_s ? rd_q : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_ram_sp_bidir.sv
// Directed plus randomized bench for ram_sp_bidir against an array-based model.
module tb_ram_sp_bidir;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] tb_drv;
    logic          tb_oe;
    wire  [DW-1:0] data;

    int pass_cnt;
    int fail_cnt;

    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] ref_rd;

    ram_sp_bidir_if #(.ADDR_WIDTH(AW)) bus ();

    ram_sp_bidir #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.slave),
        .data  (data)
    );

    assign data = tb_oe ? tb_drv : {DW{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en = we;
        bus.addr  = a;
        tb_drv    = d;
        tb_oe     = we;
    endtask

    // Reference behaviour at a rising edge, then move 1 ns past it.
    task automatic tick();
        if (rst_n) begin
            if (bus.wr_en) ref_mem[bus.addr] = tb_drv;
            else           ref_rd = ref_mem[bus.addr];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        ref_rd = 16'h0000;
    endtask

    task automatic check_all_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) check(tag, dut.mem[i], ref_mem[i]);
    endtask

    initial begin
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        pass_cnt = 0;
        fail_cnt = 0;
        rst_n    = 1'b0;
        drive(1'b0, 4'd0, 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_oe", {15'd0, dut.drive_en_s}, 16'h0000);
        check_all_mem("reset_mem");
        rst_n = 1'b1;

        // Scribble some words, then reset mid-cycle with no edge.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'(i * 3), 16'(16'h7700 + i));
            tick();
        end
        drive(1'b0, 4'd3, 16'h0000);
        tick();
        check("pre_rst_data", data, ref_rd);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_oe", {15'd0, dut.drive_en_s}, 16'h0000);
        check_all_mem("midrst_mem");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 4'd5, 16'h0000);
        tick();
        check("post_rst_rd5", data, 16'h0000);

        // Full write sweep then read sweep.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 4'(i), 16'(16'h1000 + i));
            tick();
            check("wr_oe", {15'd0, dut.drive_en_s}, 16'h0000);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 4'(i), 16'h0000);
            tick();
            check("sweep_mem", dut.mem[i], 16'(16'h1000 + i));
            check("sweep_data", data, 16'(16'h1000 + i));
        end

        // Preset to 0xAAAA, then read-only sweep must leave storage alone.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 4'(i), 16'hAAAA);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 4'(i), 16'h5555);
            tick();
            check("rdonly_data", data, 16'hAAAA);
        end
        check_all_mem("rdonly_mem");

        // Direction switch on addr 0.
        drive(1'b1, 4'd0, 16'h1234);
        tick();
        check("dir_oe_wr", {15'd0, dut.drive_en_s}, 16'h0000);
        check("dir_mem0", dut.mem[0], 16'h1234);
        drive(1'b0, 4'd0, 16'h0000);
        #1;
        check("dir_old_rd", data, ref_rd);
        tick();
        check("dir_new_rd", data, 16'h1234);

        // Back-to-back write then read of the top address.
        drive(1'b1, 4'd15, 16'hBEEF);
        tick();
        drive(1'b0, 4'd15, 16'h0000);
        tick();
        check("b2b_data", data, 16'hBEEF);
        check_all_mem("b2b_mem");

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, DEPTH - 1));
            d  = 16'($urandom);
            drive(we, a, d);
            tick();
            check("rnd_oe", {15'd0, dut.drive_en_s}, {15'd0, ~we});
            if (!we) check("rnd_data", data, ref_rd);
            else     check("rnd_mem", dut.mem[a], ref_mem[a]);
        end
        check_all_mem("rnd_final_mem");

        // Reset while the block drives 0x5A5A.
        drive(1'b1, 4'd3, 16'h5A5A);
        tick();
        drive(1'b0, 4'd3, 16'h0000);
        tick();
        check("rdrst_data", data, 16'h5A5A);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rdrst_oe", {15'd0, dut.drive_en_s}, 16'h0000);
        check_all_mem("rdrst_mem");
        @(posedge clk);
        #1;
        check("rdrst_hold_mem3", dut.mem[3], 16'h0000);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end
endmodule
